exhaustive_equiv_checker: RTL and testbench
===========================================

// Module: exhaustive_equiv_checker
// PURPOSE
//  Synthesisable, parametrised successor to our exhaustive 4-input stimulus bench.
//  - Sweeps every N_IN-bit input vector, 0 .. 2^N_IN-1, on vec_out.
//  - Samples N_IMPL single-bit responses from parallel implementations of one function.
//  - Counts vectors on which the implementations disagree and records the first failure.
//  - Sits beside the DUT implementations; usable on FPGA or in simulation.
// PARAMETERS
//  N_IN    4   input vector width; sweep length = 2^N_IN vectors
//  N_IMPL  3   number of implementations compared (>=2)
//  SETTLE  1   cycles vec_out is held before sampling (>=1)
//  GOLDEN  16'h0000  2^N_IN-bit truth table; bit v = expected output for vector v
//                    (used only with EQC_GOLDEN_EN)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  start      in   1          begin sweep; honoured in IDLE or DONE only
//  vec_out    out  N_IN       current stimulus vector to all implementations
//  resp_in    in   N_IMPL     bit i = output of implementation i
//  busy       out  1          sweep in progress
//  done       out  1          sweep complete; level, held until start or rst
//  pass       out  1          1 iff done and err_cnt==0; 0 whenever done==0
//  err_cnt    out  N_IN+1     number of mismatching vectors (max 2^N_IN, no overflow)
//  first_err_valid  out  1    a mismatch has been recorded this sweep
//  first_err_vec    out  N_IN vector of the first mismatch
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE. Applies on any cycle, mid-sweep included.
//    A mid-sweep reset abandons the sweep; done is not asserted.
//  - States: IDLE, DRIVE, SAMPLE, DONE.
//  - IDLE/DONE + start: go to DRIVE next cycle.
//    - vec_out=0, err_cnt=0, first_err_valid=0, first_err_vec=0.
//    - done=0, pass=0, busy=1.
//  - DRIVE: hold vec_out for SETTLE cycles (settle counter), then go to SAMPLE.
//  - SAMPLE: evaluate the mismatch on resp_in.
//    - If mismatch: err_cnt += 1.
//    - If mismatch and first_err_valid==0: first_err_vec=vec_out, first_err_valid=1.
//    - If vec_out == 2^N_IN-1: go to DONE (no wrap to 0).
//    - Else: vec_out += 1 and return to DRIVE.
//  - Cost per vector: SETTLE+1 cycles.
//  - DONE is entered 2^N_IN*(SETTLE+1) cycles after the first DRIVE cycle.
//  - In DONE: busy=0, done=1, pass=(err_cnt==0).
//    - vec_out, err_cnt and first_err_* hold their values.
//  - start asserted while busy is ignored; it has no effect on the sweep.
//  - start in DONE restarts a new sweep; counters clear as above.
//  - Default mismatch: any resp_in[i] != resp_in[0], for i = 1..N_IMPL-1.
//  - All outputs are registered; resp_in is sampled only in SAMPLE.
// CONFIGURATION
//  EQC_GOLDEN_EN defined:
//    - Mismatch = any resp_in[i] != GOLDEN[vec_out], for i = 0..N_IMPL-1.
//    - This catches implementations that agree with each other but are all wrong.
//  EQC_GOLDEN_EN undefined:
//    - Relative comparison only; GOLDEN is ignored.
//    - No GOLDEN lookup logic is synthesised.
// TESTING
//  (N_IN=4, N_IMPL=3, SETTLE=1 unless noted)
//  1. All three channels = same function, start pulse
//     -> done after 32 cycles; pass=1, err_cnt=0, first_err_valid=0.
//  2. Channel 2 inverted only at vector 6
//     -> err_cnt=1, first_err_vec=6, first_err_valid=1, pass=0.
//  3. Channel 1 inverted on all vectors
//     -> err_cnt=16, first_err_vec=0, pass=0.
//  4. start re-pulsed at cycle 10 of a sweep; later, rst at cycle 20 of a new sweep
//     -> first: sweep unaffected, same done time;
//     -> second: all outputs 0 and done never asserts.
//  5. SETTLE=3, vectors 3 and 12 mismatched, then start again from DONE
//     -> first sweep done after 64 cycles, err_cnt=2, first_err_vec=3;
//     -> second start clears counters and the second sweep gives identical results.
//  6. EQC_GOLDEN_EN, GOLDEN=16'h8000, all channels = AND4
//     -> pass=1; GOLDEN=16'h0001 -> err_cnt=2.

Source files
------------

// File: rtl/exhaustive_equiv_checker.sv
// Exhaustive equivalence checker: sweeps every N_IN-bit vector and compares N_IMPL responses.
// Define EQC_GOLDEN_EN to check every response against the GOLDEN truth table instead of channel 0.
module exhaustive_equiv_checker #(
    parameter int N_IN   = 4,
    parameter int N_IMPL = 3,
    parameter int SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0] GOLDEN = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   vec_out,
    input  logic [N_IMPL-1:0] resp_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_cnt,
    output logic              first_err_valid,
    output logic [N_IN-1:0]   first_err_vec
);
    localparam int NV = 1 << N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    if (N_IMPL < 2 || SETTLE < 1 || $bits(GOLDEN) != NV) begin : g_bad_params
        $error("exhaustive_equiv_checker: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     settle_q;
    logic [N_IN-1:0]   vec_q, fvec_q;
    logic [N_IN:0]     err_q, err_d;
    logic              busy_q, done_q, pass_q, fvld_q;
    logic              mismatch;

    always_comb begin
`ifdef EQC_GOLDEN_EN
        mismatch = (resp_in != {N_IMPL{GOLDEN[vec_q]}});
`else
        mismatch = (resp_in[N_IMPL-1:1] != {(N_IMPL-1){resp_in[0]}});
`endif
        err_d = err_q + {{N_IN{1'b0}}, mismatch};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            vec_q    <= '0;
            fvec_q   <= '0;
            err_q    <= '0;
            fvld_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q  <= DRIVE;
                        settle_q <= '0;
                        vec_q    <= '0;
                        fvec_q   <= '0;
                        err_q    <= '0;
                        fvld_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (settle_q == CW'(SETTLE - 1)) begin
                        state_q  <= SAMPLE;
                        settle_q <= '0;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    err_q <= err_d;
                    if (mismatch && !fvld_q) begin
                        fvld_q <= 1'b1;
                        fvec_q <= vec_q;
                    end
                    // Last vector: stop here so vec_out keeps showing 2^N_IN-1 in DONE.
                    if (&vec_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end else begin
                        state_q <= DRIVE;
                        vec_q   <= vec_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vec_out         = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_q;
    assign first_err_valid = fvld_q;
    assign first_err_vec   = fvec_q;
endmodule

// File: tb/tb_exhaustive_equiv_checker.sv
// Bench for exhaustive_equiv_checker: two instances (SETTLE=1 and SETTLE=3) fed from per-channel truth tables.
module tb_exhaustive_equiv_checker;
    logic       clk = 1'b0;
    logic       rst   [2];
    logic       start [2];
    logic [3:0] vec   [2];
    logic [2:0] resp  [2];
    logic       busy  [2];
    logic       done  [2];
    logic       pass  [2];
    logic [4:0] errc  [2];
    logic       fvld  [2];
    logic [3:0] fvec  [2];
    logic [15:0] tt   [2][3];

    int tests = 0;
    int fails = 0;

    localparam logic [15:0] GOLD0 = 16'h8000;
    localparam logic [15:0] GOLD1 = 16'h0001;

    always #5 clk = ~clk;

    exhaustive_equiv_checker #(.N_IN(4), .N_IMPL(3), .SETTLE(1), .GOLDEN(GOLD0)) u0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .vec_out(vec[0]), .resp_in(resp[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(errc[0]),
        .first_err_valid(fvld[0]), .first_err_vec(fvec[0]));

    exhaustive_equiv_checker #(.N_IN(4), .N_IMPL(3), .SETTLE(3), .GOLDEN(GOLD1)) u1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .vec_out(vec[1]), .resp_in(resp[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(errc[1]),
        .first_err_valid(fvld[1]), .first_err_vec(fvec[1]));

    // Each implementation is a truth table looked up by the current stimulus vector.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            resp[d] = '0;
            for (int i = 0; i < 3; i++) resp[d][i] = tt[d][i][vec[d]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: walk all 16 vectors, count mismatching ones and note the first.
    task automatic model(input int d, output int cnt, output int first);
        logic [15:0] gold;
        bit mm;
        gold  = (d == 0) ? GOLD0 : GOLD1;
        cnt   = 0;
        first = 0;
        for (int v = 0; v < 16; v++) begin
            mm = 1'b0;
`ifdef EQC_GOLDEN_EN
            for (int i = 0; i < 3; i++) if (tt[d][i][v] != gold[v]) mm = 1'b1;
`else
            for (int i = 1; i < 3; i++) if (tt[d][i][v] != tt[d][0][v]) mm = 1'b1;
`endif
            if (mm) begin
                if (cnt == 0) first = v;
                cnt++;
            end
        end
    endtask

    // Start a sweep, optionally re-pulse start at cycle `repulse`, and check the finished result.
    task automatic sweep(input int d, input int repulse, input string tag);
        int ecnt, efirst, cyc;
        model(d, ecnt, efirst);
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
        chk({tag, ".busy_at_start"}, int'(busy[d]), 1);
        chk({tag, ".done_at_start"}, int'(done[d]), 0);
        chk({tag, ".vec_at_start"},  int'(vec[d]), 0);
        cyc = 0;
        while (!done[d] && cyc < 2000) begin
            if (cyc == repulse) start[d] = 1'b1;
            tick();
            start[d] = 1'b0;
            cyc++;
        end
        chk({tag, ".cycles"}, cyc, 16 * ((d == 0) ? 2 : 4));
        chk({tag, ".done"},    int'(done[d]), 1);
        chk({tag, ".busy"},    int'(busy[d]), 0);
        chk({tag, ".pass"},    int'(pass[d]), (ecnt == 0) ? 1 : 0);
        chk({tag, ".err_cnt"}, int'(errc[d]), ecnt);
        chk({tag, ".fvld"},    int'(fvld[d]), (ecnt != 0) ? 1 : 0);
        chk({tag, ".fvec"},    int'(fvec[d]), efirst);
        chk({tag, ".vec_end"}, int'(vec[d]), 15);
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, ".vec"},  int'(vec[d]), 0);
        chk({tag, ".busy"}, int'(busy[d]), 0);
        chk({tag, ".done"}, int'(done[d]), 0);
        chk({tag, ".pass"}, int'(pass[d]), 0);
        chk({tag, ".err"},  int'(errc[d]), 0);
        chk({tag, ".fvld"}, int'(fvld[d]), 0);
        chk({tag, ".fvec"}, int'(fvec[d]), 0);
    endtask

    initial begin
        logic [15:0] r;
        int seen;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            start[d] = 1'b0;
            for (int i = 0; i < 3; i++) tt[d][i] = '0;
        end
        tick(); tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");

        // Identical functions
        r = 16'($urandom);
        for (int i = 0; i < 3; i++) tt[0][i] = r;
        sweep(0, -1, "t1_same");

        // Channel 2 wrong only at vector 6
        tt[0][2] = r ^ 16'h0040;
        sweep(0, -1, "t2_vec6");

        // Channel 1 inverted everywhere
        tt[0][2] = r;
        tt[0][1] = ~r;
        sweep(0, -1, "t3_inv");

        // Stray start mid-sweep is ignored
        r = 16'($urandom);
        tt[0][0] = r;
        tt[0][1] = r ^ 16'($urandom & $urandom);
        tt[0][2] = r ^ 16'($urandom & $urandom & $urandom);
        sweep(0, 10, "t4_repulse");

        // Reset at cycle 20 of a new sweep abandons it
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk_zero(0, "t4_rst");
        seen = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (done[0] || busy[0]) seen = 1;
        end
        chk("t4_rst.no_done", seen, 0);

        // SETTLE=3, mismatches at vectors 3 and 12, swept twice
        r = 16'($urandom);
        tt[1][0] = r;
        tt[1][1] = r;
        tt[1][2] = r ^ 16'h1008;
        sweep(1, -1, "t5_first");
        sweep(1, -1, "t5_again");

        // AND4 on all channels against both golden tables
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 3; i++) tt[d][i] = 16'h8000;
        sweep(0, -1, "t6_and4_g8000");
        sweep(1, -1, "t6_and4_g0001");

        // Random sparse disagreements
        for (int k = 0; k < 4; k++) begin
            for (int d = 0; d < 2; d++) begin
                r = 16'($urandom);
                tt[d][0] = r ^ 16'($urandom & $urandom & $urandom);
                tt[d][1] = r ^ 16'($urandom & $urandom & $urandom);
                tt[d][2] = r ^ 16'($urandom & $urandom);
            end
            sweep(0, -1, "rand0");
            sweep(1, -1, "rand1");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
